// File: rtl/elevator_pkg.sv
// elevator_pkg: shared constants for the elevator status machine slice.
//  - DEFAULT_N_FLOORS / DEFAULT_FLOOR_W : default request-vector and floor-index widths
//  - ST_UP / ST_DOWN / ST_OPEN / ST_CLOSE : bit positions inside the 4-bit car status word
//  - hall_clear_ok() : decides whether a hall call in one direction may be served
package elevator_pkg;

  localparam int DEFAULT_N_FLOORS = 8;
  localparam int DEFAULT_FLOOR_W  = 3;

  localparam int ST_UP    = 3;
  localparam int ST_DOWN  = 2;
  localparam int ST_OPEN  = 1;
  localparam int ST_CLOSE = 0;

  // A hall call is served when the car travels in that call's direction,
  // or when the car is idle (no direction bit set at all).
  function automatic logic hall_clear_ok(input logic own_dir, input logic other_dir);
    return own_dir | ~(own_dir | other_dir);
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// debounce_edge: 2-FF synchroniser, debounce counter, debounced level and rise pulse
// for one raw mechanical input.
//  clk   in  1  sampling clock
//  rst   in  1  asynchronous active-low reset
//  din   in  1  raw asynchronous input
//  level out 1  debounced level (registered)
//  rise  out 1  one-cycle pulse, registered, one cycle after level goes 0->1
module debounce_edge #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             deb_r;
  logic             deb_d_r;
  logic             rise_r;
  logic             differ_s;
  logic             accept_s;

  // The change is accepted on the DEB_CYCLES-th consecutive differing sample,
  // so no sample is lost between acceptance and the next count.
  always_comb begin
    differ_s = sync2_r ^ deb_r;
    if (differ_s && (cnt_r == CNT_W'(DEB_CYCLES - 1))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Synchroniser, debounce counter, debounced level and registered rise detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      deb_r   <= 1'b0;
      deb_d_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (accept_s) begin
        cnt_r <= {CNT_W{1'b0}};
        deb_r <= ~deb_r;
      end else if (differ_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
        deb_r <= deb_r;
      end else begin
        cnt_r <= {CNT_W{1'b0}};
        deb_r <= deb_r;
      end
      deb_d_r <= deb_r;
      rise_r  <= deb_r & ~deb_d_r;
    end
  end

  assign level = deb_r;
  assign rise  = rise_r;

endmodule

// File: rtl/call_request_latch.sv
// call_request_latch: debounces cabin switches and hall buttons, latches them as
// pending requests and clears each one when the car serves it.
// Optional build macro: CALL_CANCEL_EN (a cabin-mode re-press toggles the request off).
//  clk        in  1         scan-rate clock
//  rst        in  1         asynchronous active-low reset
//  sw         in  N_FLOORS  raw cabin/floor-select switches
//  btnc       in  1         raw mode select (0 cabin, 1 hall)
//  btnu/btnd  in  1         raw hall up / down buttons
//  floor      in  FLOOR_W   current car floor
//  status     in  4         car status [3]=up [2]=down [1]=open [0]=close
//  cabin_req / up_call / down_call  out N_FLOORS  latched requests
//  nextup / nextdown / pending      out 1         request above / below / anywhere
module call_request_latch
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = DEFAULT_N_FLOORS,
  parameter int FLOOR_W    = DEFAULT_FLOOR_W,
  parameter int DEB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] sw,
  input  logic                btnc,
  input  logic                btnu,
  input  logic                btnd,
  input  logic [FLOOR_W-1:0]  floor,
  input  logic [3:0]          status,
  output logic [N_FLOORS-1:0] cabin_req,
  output logic [N_FLOORS-1:0] up_call,
  output logic [N_FLOORS-1:0] down_call,
  output logic                nextup,
  output logic                nextdown,
  output logic                pending
);

  // No hall-up call exists at the top floor, no hall-down call at the bottom.
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  logic [N_FLOORS-1:0] sw_lvl_s;
  logic [N_FLOORS-1:0] sw_rise_s;
  logic                mode_lvl_s;
  logic                mode_rise_s;
  logic                up_lvl_s;
  logic                up_rise_s;
  logic                dn_lvl_s;
  logic                dn_rise_s;
  logic                unused_s;

  logic [N_FLOORS-1:0] floor_hot_s;
  logic                floor_ok_s;
  logic [N_FLOORS-1:0] set_cab_s;
  logic [N_FLOORS-1:0] set_up_s;
  logic [N_FLOORS-1:0] set_dn_s;
  logic [N_FLOORS-1:0] clr_cab_s;
  logic [N_FLOORS-1:0] clr_up_s;
  logic [N_FLOORS-1:0] clr_dn_s;
  logic [N_FLOORS-1:0] cab_nxt_s;
  logic [N_FLOORS-1:0] up_nxt_s;
  logic [N_FLOORS-1:0] dn_nxt_s;
  logic [N_FLOORS-1:0] any_req_s;
  logic                above_s;
  logic                below_s;

  logic [N_FLOORS-1:0] cabin_req_r;
  logic [N_FLOORS-1:0] up_call_r;
  logic [N_FLOORS-1:0] down_call_r;

  for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_sw_deb
    debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
      .clk   (clk),
      .rst   (rst),
      .din   (sw[gi]),
      .level (sw_lvl_s[gi]),
      .rise  (sw_rise_s[gi])
    );
  end

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_mode_deb (
    .clk (clk), .rst (rst), .din (btnc), .level (mode_lvl_s), .rise (mode_rise_s)
  );

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_up_deb (
    .clk (clk), .rst (rst), .din (btnu), .level (up_lvl_s), .rise (up_rise_s)
  );

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_dn_deb (
    .clk (clk), .rst (rst), .din (btnd), .level (dn_lvl_s), .rise (dn_rise_s)
  );

  // Only edges of the buttons and the mode level are meaningful here.
  assign unused_s = mode_rise_s ^ up_lvl_s ^ dn_lvl_s ^ status[ST_CLOSE];

  // One-hot decode of the car floor; an out-of-range floor decodes to nothing.
  always_comb begin
    floor_hot_s = {N_FLOORS{1'b0}};
    floor_ok_s  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (32'(floor) == i) begin
        floor_hot_s[i] = 1'b1;
        floor_ok_s     = 1'b1;
      end else begin
        floor_hot_s[i] = 1'b0;
      end
    end
  end

  // Request sets from debounced presses, service clears, and next-state merge (clear wins).
  always_comb begin
    if (mode_lvl_s) begin
      set_cab_s = {N_FLOORS{1'b0}};
    end else begin
      set_cab_s = sw_rise_s;
    end

    if (mode_lvl_s && up_rise_s) begin
      set_up_s = sw_lvl_s & UP_MASK;
    end else begin
      set_up_s = {N_FLOORS{1'b0}};
    end

    if (mode_lvl_s && dn_rise_s) begin
      set_dn_s = sw_lvl_s & DN_MASK;
    end else begin
      set_dn_s = {N_FLOORS{1'b0}};
    end

    if (status[ST_OPEN]) begin
      clr_cab_s = floor_hot_s;
    end else begin
      clr_cab_s = {N_FLOORS{1'b0}};
    end

    if (status[ST_OPEN] && hall_clear_ok(status[ST_UP], status[ST_DOWN])) begin
      clr_up_s = floor_hot_s;
    end else begin
      clr_up_s = {N_FLOORS{1'b0}};
    end

    if (status[ST_OPEN] && hall_clear_ok(status[ST_DOWN], status[ST_UP])) begin
      clr_dn_s = floor_hot_s;
    end else begin
      clr_dn_s = {N_FLOORS{1'b0}};
    end

`ifdef CALL_CANCEL_EN
    // A press on an already latched cabin request withdraws it.
    cab_nxt_s = (cabin_req_r ^ set_cab_s) & ~clr_cab_s;
`else
    cab_nxt_s = (cabin_req_r | set_cab_s) & ~clr_cab_s;
`endif
    up_nxt_s = (up_call_r   | set_up_s) & ~clr_up_s;
    dn_nxt_s = (down_call_r | set_dn_s) & ~clr_dn_s;
  end

  // Request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cabin_req_r <= {N_FLOORS{1'b0}};
      up_call_r   <= {N_FLOORS{1'b0}};
      down_call_r <= {N_FLOORS{1'b0}};
    end else begin
      cabin_req_r <= cab_nxt_s;
      up_call_r   <= up_nxt_s;
      down_call_r <= dn_nxt_s;
    end
  end

  // Direction look-ahead over all request kinds relative to the car floor.
  always_comb begin
    any_req_s = cabin_req_r | up_call_r | down_call_r;
    above_s   = 1'b0;
    below_s   = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (32'(floor) < i) begin
        above_s = above_s | any_req_s[i];
      end else if (32'(floor) > i) begin
        below_s = below_s | any_req_s[i];
      end else begin
        above_s = above_s;
      end
    end
  end

  assign cabin_req = cabin_req_r;
  assign up_call   = up_call_r;
  assign down_call = down_call_r;
  assign nextup    = above_s & floor_ok_s;
  assign nextdown  = below_s & floor_ok_s;
  assign pending   = |any_req_s;

endmodule

// File: tb/tb_call_request_latch.sv
// Bench for call_request_latch: directed scenarios followed by random glitchy input,
// all compared against a window-based behavioural model of the debounce and latch rules.
module tb_call_request_latch;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int NI = N + 3;  // sw[0..7], btnc, btnu, btnd

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  sw = 8'h00;
  logic          btnc = 1'b0;
  logic          btnu = 1'b0;
  logic          btnd = 1'b0;
  logic [FW-1:0] floor = 3'd0;
  logic [3:0]    status = 4'b0000;
  logic [N-1:0]  cabin_req;
  logic [N-1:0]  up_call;
  logic [N-1:0]  down_call;
  logic          nextup;
  logic          nextdown;
  logic          pending;

  int errors = 0;
  int checks = 0;

  // Model state: raw samples of the last six edges, accepted levels, rise pulses, requests.
  logic [NI-1:0] win [0:5];
  logic [NI-1:0] m_lvl;
  logic [NI-1:0] m_lvl_prev;
  logic [NI-1:0] m_rise;
  logic [N-1:0]  m_cab;
  logic [N-1:0]  m_up;
  logic [N-1:0]  m_dn;

  call_request_latch dut (
    .clk(clk), .rst(rst), .sw(sw), .btnc(btnc), .btnu(btnu), .btnd(btnd),
    .floor(floor), .status(status), .cabin_req(cabin_req), .up_call(up_call),
    .down_call(down_call), .nextup(nextup), .nextdown(nextdown), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 6; s++) win[s] = '0;
    m_lvl = '0; m_lvl_prev = '0; m_rise = '0;
    m_cab = '0; m_up = '0; m_dn = '0;
  endtask

  task automatic compare_model();
    logic [N-1:0] any;
    logic e_up, e_dn;
    any = m_cab | m_up | m_dn;
    e_up = 1'b0; e_dn = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > int'(floor)) e_up |= any[i];
      if (i < int'(floor)) e_dn |= any[i];
    end
    check("cabin_req", 32'(cabin_req), 32'(m_cab));
    check("up_call",   32'(up_call),   32'(m_up));
    check("down_call", 32'(down_call), 32'(m_dn));
    check("nextup",    32'(nextup),    32'(e_up));
    check("nextdown",  32'(nextdown),  32'(e_dn));
    check("pending",   32'(pending),   32'(|any));
  endtask

  // One clock edge: the model advances with the inputs present at the edge.
  task automatic tick();
    logic [NI-1:0] raw;
    raw = {btnd, btnu, btnc, sw};
    @(posedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
      // Latching uses the levels and pulses as they stood before this edge.
      if (!m_lvl[N]) begin
`ifdef CALL_CANCEL_EN
        m_cab = m_cab ^ m_rise[N-1:0];
`else
        m_cab = m_cab | m_rise[N-1:0];
`endif
      end
      if (m_lvl[N] && m_rise[N+1]) m_up = m_up | (m_lvl[N-1:0] & {1'b0, {(N-1){1'b1}}});
      if (m_lvl[N] && m_rise[N+2]) m_dn = m_dn | (m_lvl[N-1:0] & {{(N-1){1'b1}}, 1'b0});
      if (status[1]) begin
        m_cab[floor] = 1'b0;
        if (status[3] || !(status[3] || status[2])) m_up[floor] = 1'b0;
        if (status[2] || !(status[3] || status[2])) m_dn[floor] = 1'b0;
      end
      // A pulse follows one edge after the accepted level rose.
      m_rise     = m_lvl & ~m_lvl_prev;
      m_lvl_prev = m_lvl;
      for (int s = 5; s > 0; s--) win[s] = win[s-1];
      win[0] = raw;
      // Two edges of synchroniser delay, then four equal samples in a row are accepted.
      for (int j = 0; j < NI; j++) begin
        if (win[2][j] == win[3][j] && win[2][j] == win[4][j] && win[2][j] == win[5][j])
          m_lvl[j] = win[2][j];
      end
    end
    compare_model();
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    model_reset();

    // Reset held with toggling inputs, checked asynchronously and per edge.
    #1;
    check("rst_async_cabin", 32'(cabin_req), 32'h0);
    check("rst_async_pending", 32'(pending), 32'h0);
    for (int k = 0; k < 10; k++) begin
      sw = 8'($urandom); btnc = 1'($urandom); btnu = 1'($urandom); btnd = 1'($urandom);
      floor = 3'($urandom); status = 4'($urandom);
      tick();
    end
    sw = 8'h00; btnc = 1'b0; btnu = 1'b0; btnd = 1'b0; floor = 3'd2; status = 4'b0000;
    rst = 1'b1;
    hold(10);
    check("post_rst_all", 32'({cabin_req, up_call, down_call, nextup, nextdown, pending}), 32'h0);

    // Cabin press at floor 5 with car at floor 2: visible exactly 7 edges after first sample.
    sw = 8'h20;
    hold(7);
    check("lat_early", 32'(cabin_req), 32'h00);
    tick();
    check("lat_cabin", 32'(cabin_req), 32'h20);
    check("lat_nextup", 32'(nextup), 32'h1);
    check("lat_nextdown", 32'(nextdown), 32'h0);
    check("lat_pending", 32'(pending), 32'h1);
    sw = 8'h00;
    hold(10);

    // Glitch of three samples is never accepted.
    sw = 8'h08;
    hold(3);
    sw = 8'h00;
    hold(12);
    check("glitch", 32'(cabin_req), 32'h20);

    // Hall mode: floor 7 up and floor 0 down are ignored.
    btnc = 1'b1; hold(10);
    sw = 8'h81;  hold(10);
    btnu = 1'b1; hold(10);
    btnu = 1'b0; hold(10);
    check("hall_up", 32'(up_call), 32'h01);
    btnd = 1'b1; hold(10);
    btnd = 1'b0; hold(10);
    check("hall_down", 32'(down_call), 32'h80);
    sw = 8'h00;  hold(10);
    btnc = 1'b0; hold(10);
    check("hall_no_cabin", 32'(cabin_req), 32'h20);

    // Build cabin, up and down requests at floor 4, then serve it travelling up.
    sw = 8'h10;  hold(10);
    sw = 8'h00;  hold(10);
    btnc = 1'b1; hold(10);
    sw = 8'h10;  hold(10);
    btnu = 1'b1; hold(10);
    btnu = 1'b0; hold(10);
    btnd = 1'b1; hold(10);
    btnd = 1'b0; hold(10);
    sw = 8'h00;  hold(10);
    btnc = 1'b0; hold(10);
    check("svc_pre_up", 32'(up_call), 32'h11);
    check("svc_pre_dn", 32'(down_call), 32'h90);
    floor = 3'd4; status = 4'b1010;
    tick();
    check("svc_cabin", 32'(cabin_req), 32'h20);
    check("svc_up", 32'(up_call), 32'h01);
    check("svc_dn_kept", 32'(down_call), 32'h90);
    status = 4'b0000;
    hold(2);

    // Press absorbed at the open floor.
    floor = 3'd1; status = 4'b0010;
    sw = 8'h02; hold(10);
    sw = 8'h00; hold(10);
    check("absorb", 32'(cabin_req), 32'h20);
    status = 4'b0000;

    // Repeated press of floor 6.
    sw = 8'h40; hold(10);
    sw = 8'h00; hold(10);
    check("press6", 32'(cabin_req), 32'h60);
    sw = 8'h40; hold(10);
    sw = 8'h00; hold(10);
`ifdef CALL_CANCEL_EN
    check("repress6", 32'(cabin_req), 32'h20);
`else
    check("repress6", 32'(cabin_req), 32'h60);
`endif

    // Random glitchy stimulus with a reset in the middle.
    for (int seg = 0; seg < 80; seg++) begin
      case ($urandom_range(0, 5))
        0: sw = 8'($urandom);
        1: btnc = ~btnc;
        2: btnu = ~btnu;
        3: btnd = ~btnd;
        4: floor = 3'($urandom);
        default: status = 4'($urandom);
      endcase
      hold($urandom_range(1, 8));
      if (seg == 40) begin
        #2 rst = 1'b0;
        #1;
        check("mid_rst_async", 32'({cabin_req, up_call, down_call}), 32'h0);
        hold(2);
        rst = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
